// File: rtl/button_pkg.sv
// Shared types and 25 MHz default timing constants for the button debouncer.
// Latency: n/a. Backpressure: n/a.
package button_pkg;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_REPEAT
  } rep_state_t;

  localparam int TICK_DIV_1MS  = 25000;
  localparam int DEBOUNCE_10MS = 10;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, tick-counted debounce, edge pulses, auto-repeat FSM.
// Latency: 2 sync cycles + up to DEBOUNCE_TICKS ticks. Backpressure: none, pulses are fire-and-forget.
module debounce_channel
  import button_pkg::*;
#(
  parameter int   DEBOUNCE_TICKS      = 10,
  parameter int   REPEAT_DELAY_TICKS  = 500,
  parameter int   REPEAT_PERIOD_TICKS = 150,
  parameter logic INVERT              = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button_in,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic action
);

  localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                        REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int RW   = $clog2(RMAX + 1);

  logic          sync_meta;
  logic          sync_out;
  logic [DW-1:0] dcnt;
  logic          mismatch;
  logic          flip;
  logic          rise;
  logic          fall;

  rep_state_t    rstate;
  rep_state_t    rstate_nxt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
  logic [RW-1:0] rlimit;
  logic          rpt_now;

  assign mismatch = sync_out ^ level;
  assign flip     = mismatch & tick & (dcnt == DW'(DEBOUNCE_TICKS - 1));
  assign rise     = flip & sync_out;
  assign fall     = flip & ~sync_out;

  // A release landing on a repeat expiry suppresses the repeat.
  always_comb begin
    rstate_nxt = rstate;
    rcnt_nxt   = rcnt;
    rpt_now    = 1'b0;
    rlimit     = (rstate == REP_DELAY) ? RW'(REPEAT_DELAY_TICKS - 1) :
                                         RW'(REPEAT_PERIOD_TICKS - 1);
    case (rstate)
      REP_IDLE: begin
        if (press && repeat_en) begin
          rstate_nxt = REP_DELAY;
          rcnt_nxt   = '0;
        end
      end
      REP_DELAY, REP_REPEAT: begin
        if (!level || !repeat_en || fall) begin
          rstate_nxt = REP_IDLE;
          rcnt_nxt   = '0;
        end else if (tick) begin
          if (rcnt == rlimit) begin
            rpt_now    = 1'b1;
            rcnt_nxt   = '0;
            rstate_nxt = REP_REPEAT;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
      end
      default: begin
        rstate_nxt = REP_IDLE;
        rcnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta     <= 1'b0;
      sync_out      <= 1'b0;
      dcnt          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      action        <= 1'b0;
      rstate        <= REP_IDLE;
      rcnt          <= '0;
    end else begin
      sync_meta <= button_in ^ INVERT;
      sync_out  <= sync_meta;
      if (!mismatch) begin
        dcnt <= '0;
      end else if (tick) begin
        if (flip) begin
          level <= sync_out;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
      press         <= rise;
      release_pulse <= fall;
      repeat_pulse  <= rpt_now;
      action        <= rise | rpt_now;
      rstate        <= rstate_nxt;
      rcnt          <= rcnt_nxt;
    end
  end

endmodule

// File: rtl/button_debounce_array.sv
// CHANNELS debounced buttons sharing one tick divider; level/press/release/repeat/action per channel.
// Latency: 2 sync cycles + (DEBOUNCE_TICKS-1)*TICK_DIV+1 .. DEBOUNCE_TICKS*TICK_DIV cycles. Backpressure: none.
module button_debounce_array
  import button_pkg::*;
#(
  parameter int                CHANNELS            = 4,
  parameter int                TICK_DIV            = TICK_DIV_1MS,
  parameter int                DEBOUNCE_TICKS      = DEBOUNCE_10MS,
  parameter int                REPEAT_DELAY_TICKS  = 500,
  parameter int                REPEAT_PERIOD_TICKS = 150,
  parameter logic [CHANNELS-1:0] INVERT_MASK       = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] buttons_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  // "release" and "repeat" are reserved words, hence the _pulse suffix.
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic [CHANNELS-1:0] action
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS),
      .INVERT              (INVERT_MASK[i])
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .button_in     (buttons_in[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .action        (action[i])
    );
  end

endmodule
